// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I controller.
// Holds the controller state enum, the ALU operation class enum, the major
// opcodes the controller recognises, the datapath mux-select encodings and
// a helper that maps an opcode to its immediate format.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ADD   = 2'd0,
        SUB   = 2'd1,
        FUNCT = 2'd2
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUREG = 1'b1;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RD1   = 2'd2;

    localparam logic [1:0] SRCB_RD2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [1:0] RES_ALUREG = 2'd0;
    localparam logic [1:0] RES_DATA   = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder.
// Ports: alu_op_i (operation class from the FSM), funct3_i, funct7b5_i and
// opcode_i (instruction fields), alu_ctrl_o (ALU function code).
module alu_decoder
    import multicycle_pkg::*;
(
    input  alu_op_e     alu_op_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [6:0]  opcode_i,
    output logic [2:0]  alu_ctrl_o
);

    // Map operation class plus funct fields onto an ALU function code
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_op_i)
            ADD: alu_ctrl_o = ALU_ADD;
            SUB: alu_ctrl_o = ALU_SUB;
            FUNCT: begin
                case (funct3_i)
                    3'b000: begin
                        // Only register-register ops use funct7[5] for sub;
                        // for addi that bit belongs to the immediate.
                        if ((opcode_i == OP_R) && funct7b5_i) begin
                            alu_ctrl_o = ALU_SUB;
                        end else begin
                            alu_ctrl_o = ALU_ADD;
                        end
                    end
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    3'b111:  alu_ctrl_o = ALU_AND;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style sequencer for the multi-cycle RV32I datapath.
// Inputs: clk, rst_n (async, active low), opcode/funct3/funct7b5 from
// instr_reg, ALU zero flag, mem_ready handshake from the unified memory.
// Outputs: memory request/write strobe, state-register enables, datapath
// mux selects, register-file write, ALU control and a sticky illegal flag.
// Outputs are combinational from the state (plus mem_ready/zero in the
// states that wait on them) and are forced to zero while rst_n is low.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter logic TRAP_ILLEGAL = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        pc_en,
    output logic        ir_en,
    output logic        rd_en,
    output logic        dr_en,
    output logic        alu_reg_en,
    output logic        reg_write,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic [2:0]  alu_ctrl,
    output logic        illegal
);

    state_e     state_q;
    state_e     state_d;
    alu_op_e    alu_op_s;
    logic [2:0] alu_ctrl_s;

    // State register; reset parks the sequencer at FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op_i   (alu_op_s),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .opcode_i   (opcode),
        .alu_ctrl_o (alu_ctrl_s)
    );

    assign alu_ctrl = rst_n ? alu_ctrl_s : ALU_ADD;

    // Next-state selection and per-state datapath controls
    always_comb begin
        state_d    = state_q;
        alu_op_s   = ADD;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        rd_en      = 1'b0;
        dr_en      = 1'b0;
        alu_reg_en = 1'b0;
        reg_write  = 1'b0;
        adr_src    = ADR_PC;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        result_src = RES_ALUREG;
        imm_src    = IMM_I;
        illegal    = 1'b0;
        if (!rst_n) begin
            // Reset drops every strobe at once, even mid memory access.
            state_d = FETCH;
        end else begin
            imm_src = imm_src_of(opcode);
            case (state_q)
                FETCH: begin
                    // pc <- pc+4 and instr_reg <- mem only when the read lands.
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    pc_en      = mem_ready;
                    ir_en      = mem_ready;
                    alu_reg_en = mem_ready;
                    if (mem_ready) begin
                        state_d = DECODE;
                    end else begin
                        state_d = FETCH;
                    end
                end
                DECODE: begin
                    // Speculatively form old_pc + imm as the branch target.
                    rd_en      = 1'b1;
                    alu_reg_en = 1'b1;
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_IMM;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = MEMADR;
                        OP_R:              state_d = EXECR;
                        OP_I:              state_d = EXECI;
                        OP_BRANCH:         state_d = BEQ;
                        OP_JAL:            state_d = JAL;
                        default: begin
                            if (TRAP_ILLEGAL) begin
                                state_d = TRAP;
                            end else begin
                                state_d = FETCH;
                            end
                        end
                    endcase
                end
                MEMADR: begin
                    alu_src_a  = SRCA_RD1;
                    alu_src_b  = SRCB_IMM;
                    alu_reg_en = 1'b1;
                    if (opcode == OP_LOAD) begin
                        state_d = MEMREAD;
                    end else begin
                        state_d = MEMWRITE;
                    end
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = ADR_ALUREG;
                    dr_en   = mem_ready;
                    if (mem_ready) begin
                        state_d = MEMWB;
                    end else begin
                        state_d = MEMREAD;
                    end
                end
                MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                    state_d    = FETCH;
                end
                MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = ADR_ALUREG;
                    if (mem_ready) begin
                        state_d = FETCH;
                    end else begin
                        state_d = MEMWRITE;
                    end
                end
                EXECR, EXECI: begin
                    alu_src_a  = SRCA_RD1;
                    alu_op_s   = FUNCT;
                    alu_reg_en = 1'b1;
                    if (state_q == EXECI) begin
                        alu_src_b = SRCB_IMM;
                    end else begin
                        alu_src_b = SRCB_RD2;
                    end
                    state_d = ALUWB;
                end
                ALUWB: begin
                    result_src = RES_ALUREG;
                    reg_write  = 1'b1;
                    state_d    = FETCH;
                end
                BEQ: begin
                    // Compare rs1-rs2; alu_reg still holds the target from DECODE.
                    alu_src_a  = SRCA_RD1;
                    alu_src_b  = SRCB_RD2;
                    alu_op_s   = SUB;
                    result_src = RES_ALUREG;
                    pc_en      = zero;
                    state_d    = FETCH;
                end
                JAL: begin
                    // pc <- target held in alu_reg while alu_reg <- old_pc+4.
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    alu_reg_en = 1'b1;
                    result_src = RES_ALUREG;
                    pc_en      = 1'b1;
                    state_d    = ALUWB;
                end
                TRAP: begin
                    illegal = 1'b1;
                    state_d = TRAP;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. The model describes each
// instruction as the sequence of control words the datapath must see, one
// per cycle, together with the mem_ready/zero values driven that cycle.
// Two instances run side by side: TRAP_ILLEGAL=1 (u_dut) and 0 (u_dut0).
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic mem_req1, mem_write1, pc_en1, ir_en1, rd_en1, dr_en1, alu_reg_en1, reg_write1, adr_src1, illegal1;
    logic [1:0] alu_src_a1, alu_src_b1, result_src1, imm_src1;
    logic [2:0] alu_ctrl1;
    logic mem_req0, mem_write0, pc_en0, ir_en0, rd_en0, dr_en0, alu_reg_en0, reg_write0, adr_src0, illegal0;
    logic [1:0] alu_src_a0, alu_src_b0, result_src0, imm_src0;
    logic [2:0] alu_ctrl0;

    logic [20:0] vec1, vec0, exp1, exp0;
    logic        chk_en = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int cnt_rw = 0, cnt_ir = 0, cnt_dr = 0, cnt_pc = 0, cnt_mw = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TRAP_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req1), .mem_write(mem_write1),
        .pc_en(pc_en1), .ir_en(ir_en1), .rd_en(rd_en1), .dr_en(dr_en1), .alu_reg_en(alu_reg_en1),
        .reg_write(reg_write1), .adr_src(adr_src1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
        .result_src(result_src1), .imm_src(imm_src1), .alu_ctrl(alu_ctrl1), .illegal(illegal1)
    );

    multicycle_ctrl #(.TRAP_ILLEGAL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req0), .mem_write(mem_write0),
        .pc_en(pc_en0), .ir_en(ir_en0), .rd_en(rd_en0), .dr_en(dr_en0), .alu_reg_en(alu_reg_en0),
        .reg_write(reg_write0), .adr_src(adr_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
        .result_src(result_src0), .imm_src(imm_src0), .alu_ctrl(alu_ctrl0), .illegal(illegal0)
    );

    assign vec1 = {mem_req1, mem_write1, pc_en1, ir_en1, rd_en1, dr_en1, alu_reg_en1, reg_write1,
                   adr_src1, alu_src_a1, alu_src_b1, result_src1, imm_src1, alu_ctrl1, illegal1};
    assign vec0 = {mem_req0, mem_write0, pc_en0, ir_en0, rd_en0, dr_en0, alu_reg_en0, reg_write0,
                   adr_src0, alu_src_a0, alu_src_b0, result_src0, imm_src0, alu_ctrl0, illegal0};

    task automatic check_vec(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b, required %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_vec("ctrl_trap1", vec1, exp1);
            check_vec("ctrl_trap0", vec0, exp0);
            if (reg_write1) cnt_rw++;
            if (ir_en1)     cnt_ir++;
            if (dr_en1)     cnt_dr++;
            if (pc_en1)     cnt_pc++;
            if (mem_write1) cnt_mw++;
        end
    end

    // ---------------- model ----------------
    function automatic logic [1:0] m_imm(input logic [6:0] op);
        if (op == 7'b0100011) return 2'd1;
        if (op == 7'b1100011) return 2'd2;
        if (op == 7'b1101111) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [2:0] m_funct_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Control word builder; imm_src follows the opcode currently presented.
    function automatic logic [20:0] v(input bit req, input bit wr, input bit pc, input bit ir,
                                      input bit rd, input bit dr, input bit ar, input bit rw,
                                      input bit adr, input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] res, input logic [2:0] alu, input bit ill);
        return {req, wr, pc, ir, rd, dr, ar, rw, adr, a, b, res, m_imm(opcode), alu, ill};
    endfunction

    // One cycle: drive inputs just after the rising edge, compare at the falling edge.
    task automatic step(input logic rdy, input logic [20:0] e, input logic [20:0] e0);
        mem_ready = rdy;
        exp1 = e;
        exp0 = e0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic rdy, input logic [20:0] e);
        step(rdy, e, e);
    endtask

    function automatic logic [20:0] f_wait();
        return v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd0, 0);
    endfunction

    task automatic do_fetch_decode(input int waits);
        for (int i = 0; i < waits; i++) step1(1'b0, f_wait());
        step1(1'b1, v(1, 0, 1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd2, 2'd2, 3'd0, 0));
        // mem_ready held high here: it must not matter outside memory states.
        step1(1'b1, v(0, 0, 0, 0, 1, 0, 1, 0, 0, 2'd1, 2'd1, 2'd0, 3'd0, 0));
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode = op;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        logic [1:0] b;
        set_instr(op, f3, f7);
        b = (op == 7'b0010011) ? 2'd1 : 2'd0;
        do_fetch_decode(0);
        step1(1'b1, v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd2, b, 2'd0, m_funct_alu(op, f3, f7), 0));
        step1(1'b1, v(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
    endtask

    task automatic run_load(input int fw, input int mw);
        set_instr(7'b0000011, 3'b010, 1'b0);
        do_fetch_decode(fw);
        step1(1'b1, v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 0));
        for (int i = 0; i < mw; i++) step1(1'b0, v(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 0));
        step1(1'b1, v(1, 0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 0));
        step1(1'b0, v(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, 3'd0, 0));
    endtask

    task automatic run_store();
        set_instr(7'b0100011, 3'b010, 1'b0);
        do_fetch_decode(0);
        step1(1'b1, v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 0));
        step1(1'b1, v(1, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 0));
    endtask

    task automatic run_beq(input logic z);
        set_instr(7'b1100011, 3'b000, 1'b0);
        zero = z;
        do_fetch_decode(0);
        step1(1'b1, v(0, 0, z, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'b001, 0));
        zero = 1'b0;
    endtask

    task automatic run_jal();
        set_instr(7'b1101111, 3'b000, 1'b0);
        do_fetch_decode(0);
        step1(1'b1, v(0, 0, 1, 0, 0, 0, 1, 0, 0, 2'd1, 2'd2, 2'd0, 3'd0, 0));
        step1(1'b1, v(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
    endtask

    initial begin
        int rw0, ir0, dr0, pc0, mw0;

        // Reset held: everything must read zero even though state is FETCH.
        @(posedge clk); #1;
        mem_ready = 1'b1;
        step1(1'b1, 21'd0);
        step1(1'b0, 21'd0);
        rst_n = 1'b1;

        // add with funct7b5=1 -> sub; reg_write exactly once.
        rw0 = cnt_rw;
        run_alu(7'b0110011, 3'b000, 1'b1);
        check_int("rsub_regwrite_pulses", cnt_rw - rw0, 1);

        // lw with 2 fetch waits and 3 read waits (10 cycles).
        rw0 = cnt_rw; ir0 = cnt_ir; dr0 = cnt_dr;
        run_load(2, 3);
        check_int("lw_ir_en_pulses", cnt_ir - ir0, 1);
        check_int("lw_dr_en_pulses", cnt_dr - dr0, 1);
        check_int("lw_regwrite_pulses", cnt_rw - rw0, 1);

        // sw: one write strobe, no register write.
        rw0 = cnt_rw; mw0 = cnt_mw;
        run_store();
        check_int("sw_regwrite_pulses", cnt_rw - rw0, 0);
        check_int("sw_memwrite_cycles", cnt_mw - mw0, 1);

        // beq taken then not taken (fetch contributes one pc_en each).
        pc0 = cnt_pc;
        run_beq(1'b1);
        check_int("beq_taken_pc_en", cnt_pc - pc0, 2);
        pc0 = cnt_pc;
        run_beq(1'b0);
        check_int("beq_not_taken_pc_en", cnt_pc - pc0, 1);

        // I-type with funct7b5 set must still add; other funct3 codes.
        run_alu(7'b0010011, 3'b000, 1'b1);
        run_alu(7'b0110011, 3'b010, 1'b0);
        run_alu(7'b0110011, 3'b110, 1'b0);
        run_alu(7'b0010011, 3'b111, 1'b0);
        run_alu(7'b0110011, 3'b001, 1'b0);
        run_jal();

        // Reset in the middle of a stalled MEMREAD.
        set_instr(7'b0000011, 3'b010, 1'b0);
        do_fetch_decode(0);
        step1(1'b1, v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 0));
        chk_en = 1'b0;
        mem_ready = 1'b0;
        #2;
        check_int("memread_req_before_reset", int'(mem_req1), 1);
        check_int("memread_adr_before_reset", int'(adr_src1), 1);
        rst_n = 1'b0;
        #1;
        check_int("mem_req_drops_in_reset", int'(mem_req1), 0);
        check_vec("all_zero_in_reset", vec1, 21'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_int("fetch_req_after_reset", int'(mem_req1), 1);
        check_int("fetch_adr_after_reset", int'(adr_src1), 0);
        #1;
        run_alu(7'b0110011, 3'b111, 1'b0);

        // Unsupported opcode: TRAP for u_dut, back to FETCH for u_dut0.
        set_instr(7'b1110011, 3'b000, 1'b0);
        do_fetch_decode(0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 1), f_wait());
        end
        chk_en = 1'b0;
        check_int("trap_illegal_sticky", int'(illegal1), 1);
        check_int("notrap_illegal_clear", int'(illegal0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM that sequences the multi-cycle RV32I datapath.
- Drives the enables of the state registers: pc, old_pc/instr_reg, data_reg, rd1_reg/rd2_reg and alu_reg.
- Drives the datapath mux selects, register-file/memory write strobes and a req/ready handshake to the unified instruction/data memory.
- Sits beside the datapath in the CPU top; one instruction in flight at a time.

Parameters:
- TRAP_ILLEGAL, 1: 1 = an unsupported opcode enters sticky TRAP; 0 = it is treated as a NOP (DECODE returns to FETCH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instr_reg[6:0]
- funct3  in  3  instr_reg[14:12]
- funct7b5  in  1  instr_reg[30]
- zero  in  1  ALU zero flag (combinational ALU output)
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  qualifies mem_req as a store
- pc_en  out  1  pc register enable
- ir_en  out  1  old_pc and instr_reg enable
- rd_en  out  1  rd1_reg and rd2_reg enable
- dr_en  out  1  data_reg enable
- alu_reg_en  out  1  alu_reg enable
- reg_write  out  1  register-file write
- adr_src  out  1  memory address select: 0=pc, 1=alu_reg
- alu_src_a  out  2  ALU A select: 0=pc, 1=old_pc, 2=rd1_reg
- alu_src_b  out  2  ALU B select: 0=rd2_reg, 1=imm, 2=const 4
- result_src  out  2  result select: 0=alu_reg, 1=data_reg, 2=alu result
- imm_src  out  2  immediate format: 0=I, 1=S, 2=B, 3=J (decoded from opcode)
- alu_ctrl  out  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- State register only, asynchronous clear to FETCH. All outputs are combinational from state and inputs.
- While rst_n=0: every enable, mem_req, mem_write, reg_write and illegal = 0; selects = 0.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=2, alu_op=ADD, result_src=2.
  - pc_en = ir_en = alu_reg_en = mem_ready.
  - Stay in FETCH while mem_ready=0. Advance to DECODE when mem_ready=1.
- DECODE:
  - rd_en=1, alu_reg_en=1, alu_src_a=1, alu_src_b=1, alu_op=ADD (branch target into alu_reg).
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - other -> TRAP (TRAP_ILLEGAL=1) or FETCH (TRAP_ILLEGAL=0)
- MEMADR: alu_src_a=2, alu_src_b=1, ADD, alu_reg_en=1. Next MEMREAD if opcode=lw, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, dr_en=mem_ready. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=1, reg_write=1. Next FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready, then FETCH.
- EXECR: alu_src_a=2, alu_src_b=0, alu_op=FUNCT, alu_reg_en=1. Next ALUWB.
- EXECI: as EXECR but alu_src_b=1. Next ALUWB.
- ALUWB: result_src=0, reg_write=1. Next FETCH.
- BEQ:
  - alu_src_a=2, alu_src_b=0, alu_op=SUB, result_src=0, pc_en=zero.
  - Next FETCH.
- JAL:
  - alu_src_a=1, alu_src_b=2, ADD, alu_reg_en=1, result_src=0, pc_en=1 (pc <- target in alu_reg).
  - Next ALUWB (rd <- old_pc+4).
- TRAP: illegal=1, all enables 0. Exit only on reset.
- alu_ctrl decode:
  - ADD -> 000; SUB -> 001.
  - FUNCT: funct3 000 -> sub if (opcode=0110011 and funct7b5=1), else add; 010 -> slt; 110 -> or; 111 -> and; others -> 000.
- Latency with zero-wait memory, in cycles: lw 5, sw 4, R 4, I 4, beq 3, jal 4. Each mem_ready=0 cycle adds one cycle in its state.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Asynchronous reset mid-access drops mem_req immediately; on release the next state is FETCH.

Decomposition:
- Package multicycle_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP (4-bit)
  - opcode constants
  - alu_op enum: ADD, SUB, FUNCT
  - mux-select constants
- Sub-module alu_decoder (alu_op, funct3, funct7b5, opcode -> alu_ctrl), purely combinational.

Test Plan:
- add x3,x1,x2 (opcode 0110011, funct7b5=1 -> sub), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; alu_ctrl=001 in EXECR; reg_write=1 only in cycle 4; back to FETCH in cycle 5.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total; ir_en and dr_en each pulse exactly once, coincident with mem_ready.
- sw -> mem_req=mem_write=1, adr_src=1 in MEMWRITE; reg_write never asserted; 4 cycles.
- beq with zero=1, then with zero=0 -> pc_en=1 in BEQ only for the zero=1 case; both take 3 cycles.
- opcode 1110011 with TRAP_ILLEGAL=1 -> illegal=1 from the cycle after DECODE, stays in TRAP for 20 cycles with all enables 0; with TRAP_ILLEGAL=0 -> DECODE goes to FETCH.
- rst_n low for 1 cycle during MEMREAD with mem_ready=0 -> mem_req drops in the same cycle; after release FETCH is entered and mem_req=1 with adr_src=0.
